// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS datapath.
// Steps every instruction through FETCH/DECODE/EXE/MEM/WB and emits the
// per-state strobes for PC, IR, register file, ALU and data memory.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   op, funct, rt       instruction fields from the instruction register
//   zero, sign          ALU zero flag and busA[31], for branch resolution
//   mem_ready           data memory completes the access this cycle
//   pcWr, pcSrc, irWr   PC load / PC source select / IR load
//   regWr, regDst,      register file write enable, destination select,
//   memToReg            write-back source select
//   memRd, memWr        data memory requests
//   aluSrcB, extOp,     ALU operand B select, immediate extension mode,
//   aluOp               ALU operation
//   illegal             sticky undefined-instruction flag
//   state               current FSM state (debug)
//
// Build option: define MC_PERF_CNT_EN to add cyc_cnt/ins_cnt performance
// counters (cycles and retired instructions, both frozen in TRAP).
module mc_ctrl #(
  parameter int unsigned RA_IDX = 31,
  parameter int unsigned ST_W   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic [4:0]      rt,
  input  logic            zero,
  input  logic            sign,
  input  logic            mem_ready,
  output logic            pcWr,
  output logic [1:0]      pcSrc,
  output logic            irWr,
  output logic            regWr,
  output logic [1:0]      regDst,
  output logic [1:0]      memToReg,
  output logic            memRd,
  output logic            memWr,
  output logic            aluSrcB,
  output logic            extOp,
  output logic [4:0]      aluOp,
  output logic            illegal,
  output logic [ST_W-1:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ins_cnt
`endif
);

  // Elaboration-time sanity checks on the parameters
  if (ST_W < 3) begin : g_st_w_chk
    $error("mc_ctrl: ST_W must be at least 3");
  end
  if (RA_IDX > 31) begin : g_ra_idx_chk
    $error("mc_ctrl: RA_IDX must index one of 32 registers");
  end

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_ALUWB  = 3'd4;
  localparam logic [2:0] S_MEMWB  = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_LUI = 5'd7;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_DM  = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic       fn_ok;
  logic [4:0] r_alu_op;
  logic       r_type, is_alu_r, is_jr, is_j, is_jal, is_beq, is_bgez, is_bltz;
  logic       is_addiu, is_ori, is_lui, is_lw, is_sw, ins_ok;

  // R-type funct decode (jr is handled separately as a jump)
  always_comb begin : r_decode
    fn_ok    = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADDU: r_alu_op = ALU_ADD;
      FN_SUBU: r_alu_op = ALU_SUB;
      FN_OR:   r_alu_op = ALU_OR;
      FN_AND:  r_alu_op = ALU_AND;
      FN_SLT:  r_alu_op = ALU_SLT;
      FN_SLL:  r_alu_op = ALU_SLL;
      FN_SRL:  r_alu_op = ALU_SRL;
      default: fn_ok    = 1'b0;
    endcase
  end

  assign r_type   = (op == OP_RTYPE);
  assign is_alu_r = r_type && fn_ok;
  assign is_jr    = r_type && (funct == FN_JR);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_beq   = (op == OP_BEQ);
  assign is_bgez  = (op == OP_REGIMM) && (rt == RT_BGEZ);
  assign is_bltz  = (op == OP_REGIMM) && (rt == RT_BLTZ);
  assign is_addiu = (op == OP_ADDIU);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign ins_ok   = is_alu_r | is_jr | is_j | is_jal | is_beq | is_bgez | is_bltz |
                    is_addiu | is_ori | is_lui | is_lw | is_sw;

  // Next state and strobes; a cycle with rst=0 sampled emits no strobes at all
  always_comb begin : fsm_comb
    state_d  = state_q;
    pcWr     = 1'b0;
    pcSrc    = PC_SEQ;
    irWr     = 1'b0;
    regWr    = 1'b0;
    regDst   = DST_RT;
    memToReg = WB_ALU;
    memRd    = 1'b0;
    memWr    = 1'b0;
    aluSrcB  = 1'b0;
    extOp    = 1'b0;
    aluOp    = ALU_ADD;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          irWr    = 1'b1;
          pcWr    = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (is_j || is_jal) begin
            pcWr    = 1'b1;
            pcSrc   = PC_JMP;
            state_d = S_FETCH;
            if (is_jal) begin
              // link value is the PC already advanced during FETCH
              regWr    = 1'b1;
              regDst   = DST_RA;
              memToReg = WB_PC;
            end
          end else if (is_jr) begin
            pcWr    = 1'b1;
            pcSrc   = PC_JR;
            state_d = S_FETCH;
          end else if (ins_ok) begin
            state_d = S_EXE;
          end else begin
            state_d = S_TRAP;
          end
        end
        S_EXE: begin
          state_d = S_ALUWB;
          if (is_alu_r) begin
            aluOp = r_alu_op;
          end else if (is_addiu) begin
            aluSrcB = 1'b1;
            extOp   = 1'b1;
          end else if (is_ori) begin
            aluOp   = ALU_OR;
            aluSrcB = 1'b1;
          end else if (is_lui) begin
            aluOp   = ALU_LUI;
            aluSrcB = 1'b1;
          end else if (is_lw || is_sw) begin
            aluSrcB = 1'b1;
            extOp   = 1'b1;
            state_d = S_MEM;
          end else if (is_beq) begin
            aluOp   = ALU_SUB;
            pcWr    = zero;
            pcSrc   = PC_BR;
            state_d = S_FETCH;
          end else if (is_bgez || is_bltz) begin
            pcWr    = is_bgez ? ~sign : sign;
            pcSrc   = PC_BR;
            state_d = S_FETCH;
          end else begin
            state_d = S_TRAP;
          end
        end
        S_MEM: begin
          // keep the address computation and request steady until memory is ready
          aluSrcB = 1'b1;
          extOp   = 1'b1;
          memRd   = is_lw;
          memWr   = is_sw;
          if (mem_ready) begin
            state_d = is_lw ? S_MEMWB : S_FETCH;
          end
        end
        S_ALUWB: begin
          regWr   = 1'b1;
          regDst  = r_type ? DST_RD : DST_RT;
          state_d = S_FETCH;
        end
        S_MEMWB: begin
          regWr    = 1'b1;
          memToReg = WB_DM;
          state_d  = S_FETCH;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal <= 1'b1;
      end
    end
  end

  assign state = ST_W'(state_q);

`ifdef MC_PERF_CNT_EN
  // Cycle and retired-instruction counters, frozen once trapped
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt <= 32'd0;
      ins_cnt <= 32'd0;
    end else if (state_q != S_TRAP) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
        ins_cnt <= ins_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control sequencer for the MIPS datapath (pc/npc, regFile, alu, dm_4k, ext). It replaces the single-cycle combinational decoder.
- Each instruction is stepped through FETCH/DECODE/EXE/MEM/WB states.
- Per-state strobes drive PC, instruction-register, register-file and data-memory writes.
- A ready handshake on data memory allows multi-cycle memory.

Parameters:
RA_IDX, 31, register index written by jal.
ST_W, 3, width of the state encoding on the debug output.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low (rst=0 resets on next rising clk)
op  in  6  ins[31:26] from instruction register
funct  in  6  ins[5:0]
rt  in  5  ins[20:16], selects bgez (00001) / bltz (00000) under op 000001
zero  in  1  alu zero flag
sign  in  1  busA[31], for bgez/bltz
mem_ready  in  1  data memory accepts/returns this cycle
pcWr  out  1  PC register load enable
pcSrc  out  2  0=PC+4, 1=branch target, 2=jump imm26, 3=busA (jr)
irWr  out  1  instruction register load
regWr  out  1  register file write enable
regDst  out  2  0=rt, 1=rd, 2=RA_IDX
memToReg  out  2  0=alu_out, 1=dm_out, 2=PC (link)
memRd  out  1  data memory read request
memWr  out  1  data memory write request
aluSrcB  out  1  0=B register, 1=extended immediate
extOp  out  1  1=sign-extend, 0=zero-extend
aluOp  out  5  0=ADD 1=SUB 2=OR 3=AND 4=SLT 5=SLL 6=SRL 7=LUI
illegal  out  1  sticky undefined-opcode flag
state  out  ST_W  current state, debug

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, ALUWB=4, MEMWB=5, TRAP=6.
- Every strobe is 0 unless listed for the current state.
- Strobes are Moore, except the branch pcWr in EXE, which is combinational on zero/sign.
- Reset: while rst=0 at a clk edge, state<=FETCH and illegal<=0. In a cycle where rst=0 is sampled, all strobes are forced to 0 combinationally.
- FETCH:
  - irWr=1, pcWr=1, pcSrc=0.
  - Next: DECODE.
- DECODE:
  - j: pcWr=1, pcSrc=2. Next: FETCH.
  - jal: pcWr=1, pcSrc=2, regWr=1, regDst=2, memToReg=2. The link value is the PC already advanced by FETCH (PC+4). Next: FETCH.
  - jr (op 0, funct 001000): pcWr=1, pcSrc=3. Next: FETCH.
  - Other supported opcodes: next EXE.
  - Unsupported opcode or R-type funct: next TRAP.
- EXE, aluOp and source selection by instruction:
  - R-type: addu=ADD, subu=SUB, or=OR, and=AND, slt=SLT, sll=SLL, srl=SRL; aluSrcB=0.
  - addiu: ADD, extOp=1. ori: OR, extOp=0. lui: LUI. All with aluSrcB=1.
  - lw/sw: ADD, aluSrcB=1, extOp=1.
  - beq: SUB, aluSrcB=0. pcWr=zero, pcSrc=1.
  - bgez: pcWr=~sign, pcSrc=1. bltz: pcWr=sign, pcSrc=1.
  - Next: lw/sw to MEM; branches to FETCH; all others to ALUWB.
- MEM:
  - lw: memRd=1, aluOp=ADD held. sw: memWr=1, aluOp=ADD held.
  - Stays in MEM while mem_ready=0. Requests stay asserted and the address is stable.
  - When mem_ready=1: sw goes to FETCH, lw goes to MEMWB.
- ALUWB: regWr=1, memToReg=0, regDst=1 for R-type, 0 for I-type. Next: FETCH.
- MEMWB: regWr=1, regDst=0, memToReg=1. Next: FETCH.
- TRAP: illegal=1 (registered on entry, sticky). No strobes. Stays in TRAP until reset.
- Reset mid-instruction aborts with no further strobes. There are no partial writes, because every write is single-state.
- Writes to register 0 are not filtered here; regFile owns that.
- CPI: jumps 2, branches 3, ALU 4, sw 4, lw 5 (with mem_ready=1). Each extra mem_ready=0 cycle adds 1.

Optional Feature:
MC_PERF_CNT_EN:
- Defined: adds outputs cyc_cnt[31:0] and ins_cnt[31:0].
  - cyc_cnt increments every non-reset cycle.
  - ins_cnt increments on each transition into FETCH from a completing state.
  - Both clear on reset and wrap modulo 2^32.
  - Both freeze while in TRAP.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- rst=0 for 2 cycles, then rst=1 with addu $3,$1,$2 loaded → state 0,1,2,4,0; regWr=1 and regDst=1 only in ALUWB; irWr=1 only in FETCH.
- lw with mem_ready low for 3 cycles in MEM → memRd held 4 cycles, state stays 3; MEMWB asserts regWr with memToReg=1; 8 cycles total.
- beq with zero=1 → pcWr=1, pcSrc=1 in EXE. Repeat with zero=0 → pcWr=0. bgez (ins 0x07210010) with sign=0 → pcWr=1.
- jal → DECODE asserts pcWr, pcSrc=2, regWr, regDst=2, memToReg=2; back in FETCH on the next cycle.
- op=6'b111111 → TRAP, illegal=1, no strobes for 10 cycles; rst=0 pulse clears illegal and returns to FETCH.
- With MC_PERF_CNT_EN: run ori then sw → ins_cnt=2, cyc_cnt=8 after reset release.
